// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM port between a burst reader and a burst writer.
// Optional build macro SRAM_ARB_GREY_EN greyscales each read beat before it is returned.
module sram_port_arbiter #(
  parameter int ADDR_BITS     = 16,
  parameter int DATA_BITS     = 24,
  parameter int ACCESS_CYCLES = 5
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 rd_req,
  input  logic [ADDR_BITS-1:0] rd_addr,
  input  logic [4:0]           rd_len,
  output logic                 rd_grant,
  output logic                 rd_valid,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_done,
  input  logic                 wr_req,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [4:0]           wr_len,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_grant,
  output logic                 wr_data_ack,
  output logic                 wr_done,
  output logic [ADDR_BITS-1:0] address,
  output logic [DATA_BITS-1:0] w_data,
  input  logic [DATA_BITS-1:0] r_data,
  output logic                 read_enable,
  output logic                 write_enable
);

  typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST, TURN} state_t;

  localparam logic [3:0] LAST_CYC = 4'(ACCESS_CYCLES - 1);
  localparam logic [4:0] MAX_LEN  = 5'd20;
  localparam logic [ADDR_BITS-1:0] ADDR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 last_wr_q, last_wr_d;
  logic [4:0]           len_q, len_d;
  logic [4:0]           beat_q, beat_d;
  logic [3:0]           cyc_q, cyc_d;
  logic [ADDR_BITS-1:0] address_q, address_d;
  logic [DATA_BITS-1:0] w_data_q, w_data_d;
  logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
  logic                 read_enable_q, read_enable_d;
  logic                 write_enable_q, write_enable_d;
  logic                 rd_grant_q, rd_grant_d;
  logic                 wr_grant_q, wr_grant_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_data_ack_q, wr_data_ack_d;
  logic                 rd_done_q, rd_done_d;
  logic                 wr_done_q, wr_done_d;

  logic                 pick_rd;
  logic [4:0]           req_len, clamp_len;
  logic [DATA_BITS-1:0] rd_sample;

`ifdef SRAM_ARB_GREY_EN
  logic [9:0] grey_sum;
  always_comb begin
    grey_sum  = {2'b00, r_data[23:16]} + {1'b0, r_data[15:8], 1'b0} + {2'b00, r_data[7:0]};
    rd_sample = {{(DATA_BITS-8){1'b0}}, grey_sum[9:2]};
  end
`else
  assign rd_sample = r_data;
`endif

  // Reader wins when alone, or on a tie when the writer was served last.
  assign pick_rd   = rd_req && (!wr_req || last_wr_q);
  assign req_len   = pick_rd ? rd_len : wr_len;
  assign clamp_len = (req_len > MAX_LEN) ? MAX_LEN : req_len;

  always_comb begin
    state_d        = state_q;
    last_wr_d      = last_wr_q;
    len_d          = len_q;
    beat_d         = beat_q;
    cyc_d          = cyc_q;
    address_d      = address_q;
    w_data_d       = w_data_q;
    rd_data_d      = rd_data_q;
    read_enable_d  = read_enable_q;
    write_enable_d = write_enable_q;
    rd_grant_d     = 1'b0;
    wr_grant_d     = 1'b0;
    rd_valid_d     = 1'b0;
    wr_data_ack_d  = 1'b0;
    rd_done_d      = 1'b0;
    wr_done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (rd_req || wr_req) begin
          len_d  = clamp_len;
          beat_d = 5'd0;
          cyc_d  = 4'd0;
          if (pick_rd) begin
            state_d    = READ_BURST;
            last_wr_d  = 1'b0;
            rd_grant_d = 1'b1;
            if (clamp_len != 5'd0) begin
              address_d     = rd_addr;
              read_enable_d = 1'b1;
            end
          end else begin
            state_d    = WRITE_BURST;
            last_wr_d  = 1'b1;
            wr_grant_d = 1'b1;
            if (clamp_len != 5'd0) begin
              address_d      = wr_addr;
              w_data_d       = wr_data;
              wr_data_ack_d  = 1'b1;
              write_enable_d = 1'b1;
            end
          end
        end
      end

      READ_BURST, WRITE_BURST: begin
        if (len_q == 5'd0) begin
          state_d   = TURN;
          rd_done_d = (state_q == READ_BURST);
          wr_done_d = (state_q == WRITE_BURST);
        end else if (cyc_q != LAST_CYC) begin
          cyc_d = cyc_q + 4'd1;
        end else begin
          // Last cycle of a beat: capture read data, then either chain the next beat or finish.
          if (state_q == READ_BURST) begin
            rd_data_d  = rd_sample;
            rd_valid_d = 1'b1;
          end
          if (beat_q == len_q - 5'd1) begin
            state_d        = TURN;
            read_enable_d  = 1'b0;
            write_enable_d = 1'b0;
            rd_done_d      = (state_q == READ_BURST);
            wr_done_d      = (state_q == WRITE_BURST);
          end else begin
            beat_d    = beat_q + 5'd1;
            cyc_d     = 4'd0;
            address_d = address_q + ADDR_ONE;
            if (state_q == WRITE_BURST) begin
              w_data_d      = wr_data;
              wr_data_ack_d = 1'b1;
            end
          end
        end
      end

      TURN: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q        <= IDLE;
      last_wr_q      <= 1'b1;
      len_q          <= '0;
      beat_q         <= '0;
      cyc_q          <= '0;
      address_q      <= '0;
      w_data_q       <= '0;
      rd_data_q      <= '0;
      read_enable_q  <= 1'b0;
      write_enable_q <= 1'b0;
      rd_grant_q     <= 1'b0;
      wr_grant_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      wr_data_ack_q  <= 1'b0;
      rd_done_q      <= 1'b0;
      wr_done_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_wr_q      <= last_wr_d;
      len_q          <= len_d;
      beat_q         <= beat_d;
      cyc_q          <= cyc_d;
      address_q      <= address_d;
      w_data_q       <= w_data_d;
      rd_data_q      <= rd_data_d;
      read_enable_q  <= read_enable_d;
      write_enable_q <= write_enable_d;
      rd_grant_q     <= rd_grant_d;
      wr_grant_q     <= wr_grant_d;
      rd_valid_q     <= rd_valid_d;
      wr_data_ack_q  <= wr_data_ack_d;
      rd_done_q      <= rd_done_d;
      wr_done_q      <= wr_done_d;
    end
  end

  assign address      = address_q;
  assign w_data       = w_data_q;
  assign rd_data      = rd_data_q;
  assign read_enable  = read_enable_q;
  assign write_enable = write_enable_q;
  assign rd_grant     = rd_grant_q;
  assign wr_grant     = wr_grant_q;
  assign rd_valid     = rd_valid_q;
  assign wr_data_ack  = wr_data_ack_q;
  assign rd_done      = rd_done_q;
  assign wr_done      = wr_done_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with ACCESS_CYCLES=5; SRAM read data is address-derived.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        rd_req = 1'b0, wr_req = 1'b0;
  logic [15:0] rd_addr = '0, wr_addr = '0;
  logic [4:0]  rd_len = '0, wr_len = '0;
  logic [23:0] wr_data = '0;
  logic        rd_grant, rd_valid, rd_done, wr_grant, wr_data_ack, wr_done;
  logic [23:0] rd_data, w_data, r_data;
  logic [15:0] address;
  logic        read_enable, write_enable;
  logic        r_mode = 1'b0;

  int checks = 0;
  int errors = 0;

  sram_port_arbiter #(.ADDR_BITS(16), .DATA_BITS(24), .ACCESS_CYCLES(5)) dut (
    .clk(clk), .n_rst(n_rst),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_data(wr_data),
    .wr_grant(wr_grant), .wr_data_ack(wr_data_ack), .wr_done(wr_done),
    .address(address), .w_data(w_data), .r_data(r_data),
    .read_enable(read_enable), .write_enable(write_enable)
  );

  always #5 clk = ~clk;

  always_comb r_data = r_mode ? 24'h4080C0 : 24'h112233 + {8'h00, address};

  function automatic logic [23:0] exp_rd(input logic [23:0] raw);
`ifdef SRAM_ARB_GREY_EN
    int s;
    s = int'(raw[23:16]) + 2 * int'(raw[15:8]) + int'(raw[7:0]);
    return 24'(s / 4);
`else
    return raw;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(address), 0);
    chk({tag, "_wdata"}, 32'(w_data), 0);
    chk({tag, "_rdata"}, 32'(rd_data), 0);
    chk({tag, "_pulses"}, {24'h0, read_enable, write_enable, rd_grant, wr_grant,
                           rd_valid, wr_data_ack, rd_done, wr_done}, 0);
  endtask

  initial begin
    int n, we_cnt, ack_cnt, bad;

    // Reset values
    tick();
    chk_all_zero("reset");
    n_rst = 1'b1;
    tick();

    // Tie after reset: reader first, writer at cycle 13
    rd_req = 1; rd_addr = 16'h0200; rd_len = 5'd2;
    wr_req = 1; wr_addr = 16'h0300; wr_len = 5'd2; wr_data = 24'h000001;
    tick();
    chk("tie_rd_grant", 32'(rd_grant), 1);
    chk("tie_wr_nogrant", 32'(wr_grant), 0);
    rd_req = 0;
    for (int c = 2; c <= 12; c++) tick();
    chk("tie_wr_wait_c12", 32'(wr_grant), 0);
    tick();
    chk("tie_wr_grant_c13", 32'(wr_grant), 1);
    wr_req = 0;
    n = 0;
    while (!wr_done && n < 100) begin tick(); n++; end
    chk("tie_wr_done_seen", 32'(wr_done), 1);
    tick();
    rd_req = 1; wr_req = 1;
    tick();
    chk("tie2_rd_grant", 32'(rd_grant), 1);
    chk("tie2_wr_nogrant", 32'(wr_grant), 0);
    rd_req = 0; wr_req = 0;
    n = 0;
    while (!rd_done && n < 100) begin tick(); n++; end
    chk("tie2_rd_done_seen", 32'(rd_done), 1);
    tick();

    // Single read burst, len 3 at 0x0100
    rd_req = 1; rd_addr = 16'h0100; rd_len = 5'd3;
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) rd_req = 0;
      chk($sformatf("rd_grant_c%0d", c), 32'(rd_grant), (c == 1) ? 1 : 0);
      chk($sformatf("rd_re_c%0d", c), 32'(read_enable), (c <= 15) ? 1 : 0);
      chk($sformatf("rd_addr_c%0d", c), 32'(address),
          (c <= 15) ? 32'h100 + 32'((c - 1) / 5) : 32'h102);
      chk($sformatf("rd_valid_c%0d", c), 32'(rd_valid), (c == 6 || c == 11 || c == 16) ? 1 : 0);
      chk($sformatf("rd_done_c%0d", c), 32'(rd_done), (c == 16) ? 1 : 0);
      if (c == 6 || c == 11 || c == 16)
        chk($sformatf("rd_data_c%0d", c), 32'(rd_data),
            32'(exp_rd(24'h112333 + 24'((c - 6) / 5))));
    end

    // Write burst wrapping from 0xFFFF to 0x0000
    wr_req = 1; wr_addr = 16'hFFFF; wr_len = 5'd2; wr_data = 24'hAAAAAA;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (c == 1) begin wr_req = 0; wr_data = 24'h555555; end
      chk($sformatf("wr_grant_c%0d", c), 32'(wr_grant), (c == 1) ? 1 : 0);
      chk($sformatf("wr_ack_c%0d", c), 32'(wr_data_ack), (c == 1 || c == 6) ? 1 : 0);
      chk($sformatf("wr_we_c%0d", c), 32'(write_enable), (c <= 10) ? 1 : 0);
      chk($sformatf("wr_addr_c%0d", c), 32'(address), (c <= 5) ? 32'hFFFF : 32'h0000);
      chk($sformatf("wr_wdata_c%0d", c), 32'(w_data), (c <= 5) ? 32'hAAAAAA : 32'h555555);
      chk($sformatf("wr_done_c%0d", c), 32'(wr_done), (c == 11) ? 1 : 0);
      chk($sformatf("wr_re_c%0d", c), 32'(read_enable), 0);
    end

    // len 0: grant, then done next cycle, no enables
    rd_req = 1; rd_addr = 16'h0400; rd_len = 5'd0;
    tick();
    chk("len0_grant", 32'(rd_grant), 1);
    chk("len0_re_c1", 32'(read_enable), 0);
    rd_req = 0;
    tick();
    chk("len0_done", 32'(rd_done), 1);
    chk("len0_re_c2", 32'(read_enable), 0);
    chk("len0_valid", 32'(rd_valid), 0);
    tick();

    // len 25 clamps to 20 beats
    wr_req = 1; wr_addr = 16'h0010; wr_len = 5'd25; wr_data = 24'h123456;
    tick();
    chk("len25_grant", 32'(wr_grant), 1);
    wr_req = 0;
    we_cnt = 0; ack_cnt = 0; n = 0;
    while (!wr_done && n < 300) begin
      if (write_enable) we_cnt++;
      if (wr_data_ack) ack_cnt++;
      tick(); n++;
    end
    chk("len25_done_seen", 32'(wr_done), 1);
    chk("len25_we_cycles", 32'(we_cnt), 100);
    chk("len25_acks", 32'(ack_cnt), 20);
    chk("len25_last_addr", 32'(address), 32'h0023);
    tick();

    // Reset in cycle 7 of a len-4 read
    rd_req = 1; rd_addr = 16'h0500; rd_len = 5'd4;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 1) rd_req = 0;
    end
    chk("rst_pre_re", 32'(read_enable), 1);
    n_rst = 0;
    #1;
    chk_all_zero("rst_mid");
    #2;
    n_rst = 1;
    bad = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (rd_done || read_enable) bad++;
    end
    chk("rst_no_done", 32'(bad), 0);
    rd_req = 1; rd_addr = 16'h0600; rd_len = 5'd1;
    tick();
    chk("rst_regrant", 32'(rd_grant), 1);
    chk("rst_regrant_addr", 32'(address), 32'h0600);
    rd_req = 0;
    n = 0;
    while (!rd_done && n < 100) begin tick(); n++; end
    chk("rst_regrant_done", 32'(rd_done), 1);
    chk("rst_regrant_data", 32'(rd_data), 32'(exp_rd(24'h112233 + 24'h000600)));
    tick();

`ifdef SRAM_ARB_GREY_EN
    r_mode = 1;
    rd_req = 1; rd_addr = 16'h0700; rd_len = 5'd1;
    tick();
    rd_req = 0;
    n = 0;
    while (!rd_valid && n < 100) begin tick(); n++; end
    chk("grey_valid", 32'(rd_valid), 1);
    chk("grey_data", 32'(rd_data), 32'h000080);
    tick();
    r_mode = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
